// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: groups the cache-side request/response signals and the
// RAM beat bus of mem_arbiter. The master modport is the arbiter's view;
// the slave modport is the view of the caches and RAM controller.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int BENCH_WIDTH = DATA_WIDTH * LINE_WORDS
);
    logic                   i_read_i;
    logic [ADDR_WIDTH-1:0]  i_addr_i;
    logic [BENCH_WIDTH-1:0] i_data_o;
    logic                   i_done_o;
    logic                   d_read_i;
    logic                   d_write_i;
    logic [ADDR_WIDTH-1:0]  d_addr_i;
    logic [DATA_WIDTH-1:0]  d_wdata_i;
    logic [BENCH_WIDTH-1:0] d_data_o;
    logic                   d_done_o;
    logic                   ram_req_o;
    logic                   ram_we_o;
    logic [ADDR_WIDTH-1:0]  ram_addr_o;
    logic [DATA_WIDTH-1:0]  ram_wdata_o;
    logic [DATA_WIDTH-1:0]  ram_rdata_i;
    logic                   ram_ack_i;

    modport master (
        input  i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
               ram_rdata_i, ram_ack_i,
        output i_data_o, i_done_o, d_data_o, d_done_o,
               ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport slave (
        output i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
               ram_rdata_i, ram_ack_i,
        input  i_data_o, i_done_o, d_data_o, d_done_o,
               ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide RAM port between i-cache line refills
// and d-cache line refills / word writes. Refills run as LINE_WORDS beats
// assembled into a line register per port; writes are a single beat.
// Optional macro ARB_ROUND_ROBIN_EN: when both sides request, grant the side
// not granted last. Without it, the d-side always wins over the i-side.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int BENCH_WIDTH = DATA_WIDTH * LINE_WORDS
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic                   ram_req_q, ram_req_d;
    logic                   ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic [BENCH_WIDTH-1:0] i_line_q, i_line_d;
    logic [BENCH_WIDTH-1:0] d_line_q, d_line_d;
    logic                   i_done_q, i_done_d;
    logic                   d_done_q, d_done_d;
    logic                   want_d, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_d_q, last_d_d;
`endif

    // Next-state and registered-output computation for the arbiter FSM.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        base_d      = base_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        i_line_d    = i_line_q;
        d_line_d    = d_line_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        want_d      = bus.d_read_i | bus.d_write_i;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
        grant_d     = want_d && (!bus.i_read_i || !last_d_q);
`else
        grant_d     = want_d;
`endif

        case (state_q)
            IDLE: begin
                ram_req_d = 1'b0;
                ram_we_d  = 1'b0;
                beat_d    = '0;
                if (grant_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                    ram_req_d = 1'b1;
                    if (bus.d_write_i) begin
                        // A simultaneous read+write from the d-side is served as the write.
                        state_d     = D_WRITE;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = bus.d_addr_i & WORD_MASK;
                        ram_wdata_d = bus.d_wdata_i;
                    end else begin
                        state_d    = D_FILL;
                        base_d     = bus.d_addr_i & LINE_MASK;
                        ram_addr_d = bus.d_addr_i & LINE_MASK;
                    end
                end else if (bus.i_read_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                    state_d    = I_FILL;
                    ram_req_d  = 1'b1;
                    base_d     = bus.i_addr_i & LINE_MASK;
                    ram_addr_d = bus.i_addr_i & LINE_MASK;
                end
            end
            I_FILL, D_FILL: begin
                if (bus.ram_ack_i) begin
                    if (state_q == I_FILL) begin
                        i_line_d[beat_q * DATA_WIDTH +: DATA_WIDTH] = bus.ram_rdata_i;
                    end else begin
                        d_line_d[beat_q * DATA_WIDTH +: DATA_WIDTH] = bus.ram_rdata_i;
                    end
                    if (beat_q == CNT_W'(LINE_WORDS - 1)) begin
                        ram_req_d = 1'b0;
                        state_d   = DONE;
                        i_done_d  = (state_q == I_FILL);
                        d_done_d  = (state_q == D_FILL);
                    end else begin
                        // Next beat's address is presented the cycle after the ack.
                        beat_d     = beat_q + CNT_W'(1);
                        ram_addr_d = base_q + (ADDR_WIDTH'(beat_d) << 2);
                    end
                end
            end
            D_WRITE: begin
                if (bus.ram_ack_i) begin
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    state_d   = DONE;
                    d_done_d  = 1'b1;
                end
            end
            DONE: begin
                // Requesters drop their request on done, so nothing is sampled here.
                ram_req_d = 1'b0;
                ram_we_d  = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            base_q      <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            i_line_q    <= '0;
            d_line_q    <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            i_line_q    <= i_line_d;
            d_line_q    <= d_line_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign bus.i_data_o    = i_line_q;
    assign bus.i_done_o    = i_done_q;
    assign bus.d_data_o    = d_line_q;
    assign bus.d_done_o    = d_done_q;
    assign bus.ram_req_o   = ram_req_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_wdata_o = ram_wdata_q;
endmodule
